// File: rtl/des_pkg.sv
// DES permutation constants and the reset-table helper shared by perm_engine
// and its lookup table.
package des_pkg;

    localparam int unsigned DES_P [32] = '{
        15,  6, 19, 20, 28, 11, 27, 16,
         0, 14, 22, 25,  4, 17, 30,  9,
         1,  7, 23, 13, 31, 26,  2,  8,
        18, 12, 29,  5, 21, 10,  3, 24
    };

    // Inverse of DES_P: DES_P_INV[DES_P[i]] == i.
    localparam int unsigned DES_P_INV [32] = '{
         8, 16, 22, 30, 12, 27,  1, 17,
        23, 15, 29,  5, 25, 19,  9,  0,
         7, 13, 24,  2,  3, 28, 10, 18,
        31, 11, 21,  6,  4, 26, 14, 20
    };

    // Reset content of entry i in the given bank.
    function automatic int unsigned default_entry(
        input int unsigned win,
        input int unsigned wout,
        input int unsigned des_default,
        input int unsigned bank,
        input int unsigned i
    );
        if (des_default != 0 && win == 32 && wout == 32)
            return (bank != 0) ? DES_P_INV[i] : DES_P[i];
        return i % win;
    endfunction

endpackage

// File: rtl/perm_table.sv
// Two-bank programmable permutation table with a combinational
// WIDTH_OUT-way bit-select read; bit 0 is the MSB on both words.
module perm_table
    import des_pkg::*;
#(
    parameter int unsigned WIDTH_IN    = 32,
    parameter int unsigned WIDTH_OUT   = 32,
    parameter int unsigned DES_DEFAULT = 1,
    parameter int unsigned IDX_W       = $clog2(WIDTH_IN),
    parameter int unsigned OIDX_W      = $clog2(WIDTH_OUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 wbank,
    input  logic [OIDX_W-1:0]    widx,
    input  logic [IDX_W-1:0]     wsel,
    output logic                 err,
    input  logic                 rbank,
    input  logic [WIDTH_IN-1:0]  rword,
    output logic [WIDTH_OUT-1:0] rperm
);

    typedef logic [1:0][WIDTH_OUT-1:0][IDX_W-1:0] tbl_t;

    function automatic tbl_t reset_table();
        tbl_t t;
        t = '0;
        for (int unsigned b = 0; b < 2; b++)
            for (int unsigned i = 0; i < WIDTH_OUT; i++)
                t[b][i] = IDX_W'(default_entry(WIDTH_IN, WIDTH_OUT, DES_DEFAULT, b, i));
        return t;
    endfunction

    localparam tbl_t TBL_RST = reset_table();

    tbl_t        tbl;
    logic [31:0] sel_ext;
    logic [31:0] idx_ext;
    logic        wr_ok;

    assign sel_ext = 32'(wsel);
    assign idx_ext = 32'(widx);
    assign wr_ok   = (sel_ext < WIDTH_IN) && (idx_ext < WIDTH_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl <= TBL_RST;
            err <= 1'b0;
        end else begin
            err <= we & ~wr_ok;
            if (we && wr_ok)
                tbl[wbank][widx] <= wsel;
        end
    end

    // Table indices count from the MSB, vectors from the LSB.
    always_comb begin
        rperm = '0;
        for (int unsigned i = 0; i < WIDTH_OUT; i++)
            rperm[WIDTH_OUT-1-i] = rword[WIDTH_IN-1-32'(tbl[rbank][i])];
    end

endmodule

// File: rtl/perm_engine.sv
// Pipelined two-bank bit-permutation engine: lookup at acceptance, then the
// S1/S2 valid/ready pipeline with full-rate backpressure handling.
module perm_engine
    import des_pkg::*;
#(
    parameter int unsigned WIDTH_IN    = 32,
    parameter int unsigned WIDTH_OUT   = 32,
    parameter int unsigned DES_DEFAULT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH_IN-1:0]          in_data,
    input  logic                         in_bank,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH_OUT-1:0]         out_data,
    input  logic                         cfg_we,
    input  logic                         cfg_bank,
    input  logic [$clog2(WIDTH_OUT)-1:0] cfg_idx,
    input  logic [$clog2(WIDTH_IN)-1:0]  cfg_sel,
    output logic                         cfg_err
);

    localparam int unsigned IDX_W = $clog2(WIDTH_IN);

    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s1_adv;
    logic                 s2_adv;
    logic                 accept;
    logic [WIDTH_OUT-1:0] s1_data;
    logic [WIDTH_OUT-1:0] perm;

    perm_table #(
        .WIDTH_IN    (WIDTH_IN),
        .WIDTH_OUT   (WIDTH_OUT),
        .DES_DEFAULT (DES_DEFAULT),
        .IDX_W       (IDX_W),
        .OIDX_W      ($clog2(WIDTH_OUT))
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .wbank (cfg_bank),
        .widx  (cfg_idx),
        .wsel  (cfg_sel),
        .err   (cfg_err),
        .rbank (in_bank),
        .rword (in_data),
        .rperm (perm)
    );

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_adv;
    assign in_ready  = !s1_valid || s1_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // S1 captures the permuted word, so later table writes cannot alter it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_data  <= '0;
            out_data <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= perm;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid)
                    out_data <= s1_data;
            end
        end
    end

endmodule
